// File: rtl/bit_serializer_if.sv
// Word-in / bit-out handshake bundle for bit_serializer.
// The producer uses the master modport and the serializer uses the slave modport.
interface bit_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, dout, dout_valid, frame_start, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, dout, dout_valid, frame_start, busy
  );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one-word hold buffer, MSB-first gapless bit stream on dout.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
//
// state  | meaning
// IDLE   | line at IDLE_BIT, shifter empty
// SHIFT  | data bit cnt of the current frame is on dout
// PARITY | parity bit of the current frame is on dout (parity build only)
module bit_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  bit_serializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             dout_q;
  logic             dout_valid_q;
  logic             frame_start_q;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par_q;
`endif

  logic             accept;
  logic             frame_end;
  logic             load_hold;
  logic             load_in;
  logic             to_hold;
  logic [WIDTH-1:0] load_word;

  assign accept = bus.in_valid && !hold_full;

`ifdef BIT_SERIALIZER_PARITY_EN
  assign frame_end = (state == PARITY);
`else
  assign frame_end = (state == SHIFT) && (cnt == LAST);
`endif

  // A word arriving on the last-bit edge with hold empty goes straight to the
  // shifter, so the stream stays gapless and no word is ever parked while IDLE.
  assign load_hold = frame_end && hold_full;
  assign load_in   = accept && ((state == IDLE) || (frame_end && !hold_full));
  assign to_hold   = accept && !load_in;
  assign load_word = load_hold ? hold_q : bus.in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      hold_q        <= '0;
      hold_full     <= 1'b0;
      shreg         <= '0;
      cnt           <= '0;
      dout_q        <= IDLE_BIT;
      dout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      frame_start_q <= 1'b0;

      if (to_hold) begin
        hold_q    <= bus.in_data;
        hold_full <= 1'b1;
      end else if (load_hold) begin
        hold_full <= 1'b0;
      end

      if (load_hold || load_in) begin
        shreg         <= {load_word[WIDTH-2:0], 1'b0};
        dout_q        <= load_word[WIDTH-1];
        dout_valid_q  <= 1'b1;
        frame_start_q <= 1'b1;
        cnt           <= '0;
        state         <= SHIFT;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_q         <= ^load_word;
`endif
      end else begin
        case (state)
          SHIFT: begin
            if (cnt == LAST) begin
`ifdef BIT_SERIALIZER_PARITY_EN
              dout_q <= par_q;
              state  <= PARITY;
`else
              dout_q       <= IDLE_BIT;
              dout_valid_q <= 1'b0;
              cnt          <= '0;
              state        <= IDLE;
`endif
            end else begin
              dout_q <= shreg[WIDTH-1];
              shreg  <= {shreg[WIDTH-2:0], 1'b0};
              cnt    <= cnt + 1'b1;
            end
          end
          default: begin
            dout_q       <= IDLE_BIT;
            dout_valid_q <= 1'b0;
            cnt          <= '0;
            state        <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.in_ready    = !hold_full;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = (state != IDLE) || hold_full;

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the bit-stream sequence detectors. Accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and shifts each word out MSB-first as a continuous one-bit-per-clock stream on `dout`, which drives the detector's `din`. Between words the line idles at a fixed level so the downstream detector sits in its IDLE state.

## Interface
- `WIDTH`, default 8: word width; legal range 2..32.
- `IDLE_BIT`, default 1'b1: level driven on `dout` when no data bit is being sent.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `in_data`  input  WIDTH  word to serialize.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  block can accept a word this cycle.
- `dout`  output  1  serial bit, registered.
- `dout_valid`  output  1  `dout` carries a frame bit, registered.
- `frame_start`  output  1  one-cycle pulse on the cycle the first bit of a frame is on `dout`.
- `busy`  output  1  shifter active or hold register full.

## Operation
- Storage:
  - hold register of one word, with a `hold_full` flag;
  - WIDTH-bit shift register;
  - bit counter;
  - two-state FSM, IDLE and SHIFT (plus PARITY when configured).
- Handshake:
  - `in_ready = !hold_full`, combinational from state only, with no path from `in_valid`.
  - A transfer occurs on an edge where `in_valid && in_ready`.
- Accept in IDLE with hold empty: the word loads directly into the shifter.
  - `dout` = `in_data[WIDTH-1]`, `dout_valid`=1 and `frame_start`=1 after that edge.
  - FSM goes to SHIFT with counter=0.
- Accept in SHIFT: the word goes to the hold register and `hold_full` is set.
- SHIFT: each edge outputs the next bit, MSB first, and increments the counter.
- At the edge ending the last bit of the frame:
  - Hold full: the hold word loads into the shifter, `hold_full` clears, and the next frame's MSB appears immediately with `frame_start`=1. There are zero idle cycles between frames.
  - Hold empty: FSM goes to IDLE, with `dout`=`IDLE_BIT` and `dout_valid`=0.
- Simultaneous last-bit edge and new `in_valid` while hold is full:
  - `in_ready` is already low, so the word is not taken.
  - It is accepted on the following edge, into hold, with `in_ready`=1.
- `busy` = (FSM != IDLE) || `hold_full`.
- Reset values: `dout`=`IDLE_BIT`, `dout_valid`=0, `frame_start`=0, `hold_full`=0 (so `in_ready`=1), `busy`=0, FSM=IDLE, counter=0.
- Reset mid-frame: both the in-flight word and the held word are discarded. No partial frame resumes after reset.

## Timing
- Latency: accept edge N (idle, hold empty) puts the MSB on `dout` during cycle N+1.
- Frame length F = WIDTH cycles, or WIDTH+1 with parity.
- Sustained throughput: one word per F cycles with no gaps, as long as the producer presents the next word before the current frame ends.
- `in_ready` falls the cycle after a word enters hold. It rises the cycle after hold drains into the shifter.

## Configuration
- `BIT_SERIALIZER_PARITY_EN` defined:
  - Each frame gets one extra bit after the LSB: even parity, equal to the XOR of all WIDTH data bits.
  - `dout_valid`=1 on the parity bit; F = WIDTH+1.
  - The hold-to-shifter reload happens at the end of the parity bit.
- Undefined: no PARITY state; F = WIDTH.

## Test plan
- Single word: after reset, send `in_data`=8'h55.
  - `dout` is 0,1,0,1,0,1,0,1 on cycles N+1..N+8, with `dout_valid`=1 throughout and `frame_start`=1 on N+1 only.
  - From N+9: `dout`=1, `dout_valid`=0, `busy`=0.
- Back-to-back: send 8'hA5, then 8'h3C one cycle later.
  - 16 contiguous valid bits: 1010_0101_0011_1100.
  - `frame_start` on cycles N+1 and N+9.
  - No idle cycle between the frames.
- Backpressure: hold `in_valid`=1 with three words.
  - Word 1 is accepted at N and word 2 at N+1; `in_ready`=0 from N+2 until word 2 loads into the shifter.
  - Word 3 is accepted on the next edge.
  - All 24 bits come out in order.
- Reset mid-frame: assert `rst` during bit 4 of 8'hFF with a word held.
  - `dout`=1, `dout_valid`=0 and `in_ready`=1 immediately.
  - After release, no bits are emitted without a new transfer.
- Parity (macro defined): send 8'h07.
  - `dout` is 0,0,0,0,0,1,1,1 followed by parity bit 1; `dout_valid` is high for 9 cycles.
  - 8'h03 gives parity bit 0.
- Idle level: with `IDLE_BIT`=0 and no traffic, `dout` stays 0 and `dout_valid` stays 0 for 20 cycles.
